// File: rtl/afe_spi_pkg.sv
// Shared types, AFE2256 register addresses and the power-up init table.
package afe_spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_GAP
   } state_t;

   typedef struct packed {
      logic        rw;
      logic [6:0]  addr;
      logic [15:0] data;
   } afe_frame_t;

   localparam logic [6:0] ADDR_SOFT_RESET = 7'h00;
   localparam logic [6:0] ADDR_CONFIG0    = 7'h30;
   localparam logic [6:0] ADDR_CONFIG1    = 7'h31;
   localparam logic [6:0] ADDR_TIMING0    = 7'h40;
   localparam logic [6:0] ADDR_TIMING1    = 7'h41;
   localparam logic [6:0] ADDR_GAIN       = 7'h5C;
   localparam logic [6:0] ADDR_INT_CFG    = 7'h5D;
   localparam logic [6:0] ADDR_PWR_MODE   = 7'h5E;

   // Init table; entries past the configured table length are never selected.
   function automatic afe_frame_t init_entry(input logic [4:0] i);
      afe_frame_t f;
      f = '0;
      case (i)
         5'd0:    f = '{rw: 1'b0, addr: ADDR_SOFT_RESET, data: 16'h0001};
         5'd1:    f = '{rw: 1'b0, addr: ADDR_CONFIG0,    data: 16'h0C00};
         5'd2:    f = '{rw: 1'b0, addr: ADDR_CONFIG1,    data: 16'h0008};
         5'd3:    f = '{rw: 1'b0, addr: ADDR_GAIN,       data: 16'h0041};
         5'd4:    f = '{rw: 1'b0, addr: ADDR_INT_CFG,    data: 16'h0000};
         5'd5:    f = '{rw: 1'b0, addr: ADDR_PWR_MODE,   data: 16'h0002};
         5'd6:    f = '{rw: 1'b0, addr: ADDR_TIMING0,    data: 16'h0100};
         5'd7:    f = '{rw: 1'b0, addr: ADDR_TIMING1,    data: 16'h0000};
         default: f = '0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/afe_init_rom.sv
// Combinational init-table lookup, contents come from the package.
module afe_init_rom
   import afe_spi_pkg::*;
(
   input  logic [4:0] idx,
   output afe_frame_t frame
);

   // Pure table decode
   always_comb begin
      frame = init_entry(idx);
   end

endmodule

// File: rtl/afe_spi_cmd_scheduler.sv
// Arbitrates CPU and init-table commands onto the AFE2256 SPI engine.
module afe_spi_cmd_scheduler
   import afe_spi_pkg::*;
#(
   parameter int N_INIT      = 8,
   parameter int TIMEOUT_CYC = 4096,
   parameter int GAP_CYC     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cpu_cmd_word,
   input  logic        init_start,
   input  logic        err_clr,
   output logic        spi_start,
   output logic [23:0] spi_cmd,
   input  logic        spi_busy,
   input  logic        spi_done,
   input  logic [15:0] spi_rdata,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        init_active,
   output logic        init_done,
   output logic        err_timeout,
   output logic        cpu_overrun,
   output logic [15:0] cmd_count
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);

   state_t     state, state_next;
   afe_frame_t frame_q, cpu_pend_cmd, rom_frame;
   logic       prev_trig, cpu_pend, cpu_rise, cur_init;
   logic [4:0] idx;
   logic [TW-1:0] wait_cnt;
   logic [GW-1:0] gap_cnt;
   logic       sel_cpu, sel_init, done_hit, timeout_hit;
   logic       unused_bits;

   // spi_busy and the reserved word bits are status only
   assign unused_bits = &{1'b0, spi_busy, cpu_cmd_word[30:24]};

   assign cpu_rise  = cpu_cmd_word[31] & ~prev_trig;
   assign spi_start = (state == ST_ISSUE);
   assign spi_cmd   = frame_q;
   assign busy      = (state != ST_IDLE) | cpu_pend | init_active;

   afe_init_rom u_rom (
      .idx   (idx),
      .frame (rom_frame)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next-state decode; CPU wins every IDLE decision
   always_comb begin
      state_next  = state;
      sel_cpu     = 1'b0;
      sel_init    = 1'b0;
      done_hit    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cpu_pend) begin
               sel_cpu    = 1'b1;
               state_next = ST_ISSUE;
            end else if (init_active) begin
               sel_init   = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT: begin
            if (spi_done) begin
               done_hit   = 1'b1;
               state_next = ST_GAP;
            end else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
               timeout_hit = 1'b1;
               state_next  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GW'(GAP_CYC - 1)) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // CPU trigger edge detect and single-entry pending slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_trig    <= 1'b0;
         cpu_pend     <= 1'b0;
         cpu_pend_cmd <= '0;
      end else begin
         prev_trig <= cpu_cmd_word[31];
         if (sel_cpu) cpu_pend <= 1'b0;
         if (cpu_rise && !cpu_pend) begin
            cpu_pend     <= 1'b1;
            cpu_pend_cmd <= afe_frame_t'(cpu_cmd_word[23:0]);
         end
      end
   end

   // Frame register and source tag, loaded when a command is selected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q  <= '0;
         cur_init <= 1'b0;
      end else if (sel_cpu) begin
         frame_q  <= cpu_pend_cmd;
         cur_init <= 1'b0;
      end else if (sel_init) begin
         frame_q  <= rom_frame;
         cur_init <= 1'b1;
      end
   end

   // Wait-timeout and inter-frame gap counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
         gap_cnt  <= (state == ST_GAP)  ? gap_cnt + 1'b1  : '0;
      end
   end

   // Completion bookkeeping: frame count and readback capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_count <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= done_hit & frame_q.rw;
         if (done_hit) begin
            cmd_count <= cmd_count + 1'b1;
            if (frame_q.rw) rd_data <= spi_rdata;
         end
      end
   end

   // Init sequence progress; a timed-out init frame aborts the sequence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_active <= 1'b0;
         init_done   <= 1'b0;
         idx         <= '0;
      end else if (init_start && !init_active) begin
         init_active <= 1'b1;
         init_done   <= 1'b0;
         idx         <= '0;
      end else if (done_hit && cur_init) begin
         idx <= idx + 1'b1;
         if (idx == 5'(N_INIT - 1)) begin
            init_active <= 1'b0;
            init_done   <= 1'b1;
         end
      end else if (timeout_hit && cur_init) begin
         init_active <= 1'b0;
      end
   end

   // Sticky error flags; a new error beats a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_timeout <= 1'b0;
         cpu_overrun <= 1'b0;
      end else begin
         if (timeout_hit)  err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
         if (cpu_rise && cpu_pend) cpu_overrun <= 1'b1;
         else if (err_clr)         cpu_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_afe_spi_cmd_scheduler.sv
// Directed self-checking bench for afe_spi_cmd_scheduler.
module tb_afe_spi_cmd_scheduler;

   localparam int N_INIT      = 4;
   localparam int TIMEOUT_CYC = 64;
   localparam int GAP_CYC     = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cpu_cmd_word;
   logic        init_start, err_clr;
   logic        spi_start, spi_busy, spi_done;
   logic [23:0] spi_cmd;
   logic [15:0] spi_rdata, rd_data, cmd_count;
   logic        rd_valid, busy, init_active, init_done, err_timeout, cpu_overrun;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int rdv_cnt = 0;
   logic [23:0] start_cmd[$];
   int          start_cyc[$];

   logic        engine_en = 1'b1;
   int          done_delay = 30;
   logic [15:0] rdata_val = 16'h0000;
   logic [23:0] exp_init [4];

   afe_spi_cmd_scheduler #(
      .N_INIT(N_INIT), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cpu_cmd_word(cpu_cmd_word),
      .init_start(init_start), .err_clr(err_clr),
      .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_busy(spi_busy),
      .spi_done(spi_done), .spi_rdata(spi_rdata),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .init_active(init_active), .init_done(init_done),
      .err_timeout(err_timeout), .cpu_overrun(cpu_overrun),
      .cmd_count(cmd_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every frame request and read pulse between edges
   always @(negedge clk) begin
      if (spi_start) begin
         start_cmd.push_back(spi_cmd);
         start_cyc.push_back(cyc);
      end
      if (rd_valid) rdv_cnt <= rdv_cnt + 1;
   end

   // Simple engine model: done after done_delay cycles when enabled
   initial begin
      spi_done  = 1'b0;
      spi_busy  = 1'b0;
      spi_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (spi_start && engine_en) begin
            spi_busy = 1'b1;
            repeat (done_delay) @(negedge clk);
            spi_rdata = rdata_val;
            spi_done  = 1'b1;
            @(negedge clk);
            spi_done = 1'b0;
            spi_busy = 1'b0;
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_output({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_starts(input string tag, input int target, input int budget);
      int n = 0;
      while (start_cmd.size() < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_output({tag, "_starts"}, start_cmd.size(), target);
   endtask

   task automatic apply_stimulus(input logic [31:0] word);
      @(negedge clk);
      cpu_cmd_word = word;
   endtask

   task automatic pulse_init();
      @(negedge clk);
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
   endtask

   // Hard stop if something wedges beyond every bounded wait
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int b, t0, rv0;
      exp_init[0] = 24'h000001;
      exp_init[1] = 24'h300C00;
      exp_init[2] = 24'h310008;
      exp_init[3] = 24'h5C0041;

      rst_n = 1'b0; cpu_cmd_word = '0; init_start = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_spi_start", {31'd0, spi_start}, 0);
      check_output("rst_spi_cmd", {8'd0, spi_cmd}, 0);
      check_output("rst_busy", {31'd0, busy}, 0);
      check_output("rst_cmd_count", {16'd0, cmd_count}, 0);
      rst_n = 1'b1;

      // CPU write with latency and single-start checks
      done_delay = 30;
      apply_stimulus(32'h8008_1234);
      t0 = cyc;
      wait_idle("wr", 200);
      check_output("wr_nstart", start_cmd.size(), 1);
      check_output("wr_cmd", {8'd0, start_cmd[0]}, 32'h0008_1234);
      check_output("wr_latency", start_cyc[0] - t0, 2);
      check_output("wr_count", {16'd0, cmd_count}, 1);
      check_output("wr_rdvalid", rdv_cnt, 0);
      check_output("wr_hold", {8'd0, spi_cmd}, 32'h0008_1234);
      apply_stimulus(32'h0008_1234);

      // CPU read
      rdata_val = 16'hBEEF;
      repeat (3) @(negedge clk);
      apply_stimulus(32'h8091_0000);
      wait_idle("rd", 200);
      check_output("rd_cmd", {8'd0, start_cmd[1]}, 32'h0091_0000);
      check_output("rd_data", {16'd0, rd_data}, 32'h0000_BEEF);
      check_output("rd_pulses", rdv_cnt, 1);
      check_output("rd_count", {16'd0, cmd_count}, 2);
      apply_stimulus(32'h0091_0000);
      rdata_val = 16'h0000;

      // Full init sequence
      done_delay = 10;
      b = start_cmd.size();
      pulse_init();
      check_output("init_active_set", {31'd0, init_active}, 1);
      wait_idle("init", 400);
      check_output("init_nstart", start_cmd.size() - b, 4);
      for (int i = 0; i < 4; i++)
         check_output($sformatf("init_cmd%0d", i), {8'd0, start_cmd[b+i]}, {8'd0, exp_init[i]});
      for (int i = 1; i < 4; i++)
         check_output($sformatf("init_space%0d", i),
                      {31'd0, (start_cyc[b+i] - start_cyc[b+i-1]) >= GAP_CYC + 2}, 1);
      check_output("init_done", {31'd0, init_done}, 1);
      check_output("init_active_clr", {31'd0, init_active}, 0);
      check_output("init_count", {16'd0, cmd_count}, 6);

      // CPU frame preempts between init frames 1 and 2
      b = start_cmd.size();
      pulse_init();
      check_output("pre_done_clr", {31'd0, init_done}, 0);
      wait_starts("pre", b + 2, 200);
      apply_stimulus(32'h8012_5678);
      wait_idle("pre", 400);
      check_output("pre_nstart", start_cmd.size() - b, 5);
      check_output("pre_cmd1", {8'd0, start_cmd[b+1]}, 32'h0030_0C00);
      check_output("pre_cmd_cpu", {8'd0, start_cmd[b+2]}, 32'h0012_5678);
      check_output("pre_cmd2", {8'd0, start_cmd[b+3]}, 32'h0031_0008);
      check_output("pre_cmd3", {8'd0, start_cmd[b+4]}, 32'h005C_0041);
      check_output("pre_count", {16'd0, cmd_count}, 11);
      check_output("pre_init_done", {31'd0, init_done}, 1);
      apply_stimulus(32'h0012_5678);

      // Timeout on an init frame, plus CPU overrun while pending
      engine_en = 1'b0;
      repeat (3) @(negedge clk);
      b = start_cmd.size();
      pulse_init();
      wait_starts("to", b + 1, 50);
      apply_stimulus(32'h8020_0000);
      apply_stimulus(32'h0020_0000);
      apply_stimulus(32'h8020_0000);
      @(negedge clk);
      @(negedge clk);
      check_output("ovr_set", {31'd0, cpu_overrun}, 1);
      repeat (35) @(negedge clk);
      check_output("to_early", {31'd0, err_timeout}, 0);
      repeat (35) @(negedge clk);
      check_output("to_set", {31'd0, err_timeout}, 1);
      check_output("to_init_active", {31'd0, init_active}, 0);
      check_output("to_init_done", {31'd0, init_done}, 0);
      check_output("to_count", {16'd0, cmd_count}, 11);
      apply_stimulus(32'h0020_0000);
      wait_starts("to_cpu", b + 2, 50);
      check_output("to_cpu_cmd", {8'd0, start_cmd[b+1]}, 32'h0020_0000);
      wait_idle("to", 300);
      check_output("to_nstart", start_cmd.size() - b, 2);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_output("clr_timeout", {31'd0, err_timeout}, 0);
      check_output("clr_overrun", {31'd0, cpu_overrun}, 0);

      // Reset in the middle of WAIT
      b = start_cmd.size();
      apply_stimulus(32'h8008_0001);
      wait_starts("rstw", b + 1, 20);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("rstw_busy", {31'd0, busy}, 0);
      check_output("rstw_spi_cmd", {8'd0, spi_cmd}, 0);
      check_output("rstw_rd_data", {16'd0, rd_data}, 0);
      check_output("rstw_count", {16'd0, cmd_count}, 0);
      check_output("rstw_init_done", {31'd0, init_done}, 0);
      cpu_cmd_word = 32'h0000_0000;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_output("rstw_no_start", start_cmd.size() - b, 1);

      // Trigger already high when reset releases counts as an edge
      engine_en  = 1'b1;
      done_delay = 5;
      rst_n = 1'b0;
      cpu_cmd_word = 32'h8008_00AA;
      @(negedge clk);
      rst_n = 1'b1;
      wait_idle("rel", 100);
      check_output("rel_nstart", start_cmd.size() - b, 2);
      check_output("rel_cmd", {8'd0, start_cmd[start_cmd.size()-1]}, 32'h0008_00AA);
      check_output("rel_count", {16'd0, cmd_count}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
